// File: rtl/vuart_mc.sv
// Byte FIFO with power-of-2 depth; pointers carry one extra bit to tell full from empty.
// Latency: push visible next cycle; head is read combinationally.
// Backpressure: push on full and pop on empty are ignored; the owner raises the sticky flag.
module vuart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, rptr_q;
  logic [7:0]    mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// Multi-channel virtual UART: host and device APB ports exchanging bytes through per-channel FIFOs.
// Latency: zero-wait-state APB, read data combinational from FIFO head; irq registered one cycle.
// Backpressure: none on APB; overflowing writes are dropped and empty reads return 0, both flagged.
module vuart_mc #(
  parameter int N_CHAN   = 2,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 16,
  parameter int W_TMO    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [N_CHAN-1:0] irq,
  input  logic              host_psel,
  input  logic              host_penable,
  input  logic              host_pwrite,
  input  logic [9:0]        host_paddr,
  input  logic [31:0]       host_pwdata,
  output logic [31:0]       host_prdata,
  output logic              host_pready,
  output logic              host_pslverr,
  input  logic              dev_psel,
  input  logic              dev_penable,
  input  logic              dev_pwrite,
  input  logic [15:0]       dev_paddr,
  input  logic [31:0]       dev_pwdata,
  output logic [31:0]       dev_prdata,
  output logic              dev_pready,
  output logic              dev_pslverr
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic       h_acc, d_acc;
  logic [2:0] h_ch, d_ch;
  logic [1:0] h_reg, d_reg;
  logic       unused_bits;

  logic [31:0] h_stat [N_CHAN];
  logic [31:0] h_fifo [N_CHAN];
  logic [31:0] d_stat [N_CHAN];
  logic [31:0] d_fifo [N_CHAN];
  logic [31:0] d_ctrl [N_CHAN];
  logic [31:0] d_tmo  [N_CHAN];

  assign h_acc = host_psel && host_penable;
  assign d_acc = dev_psel && dev_penable;
  assign h_ch  = host_paddr[6:4];
  assign d_ch  = dev_paddr[6:4];
  assign h_reg = host_paddr[3:2];
  assign d_reg = dev_paddr[3:2];

  assign host_pready = 1'b1;
  assign dev_pready  = 1'b1;
  assign unused_bits = ^{host_paddr, dev_paddr, host_pwdata, dev_pwdata};

  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    logic             h_sel, d_sel;
    logic             rx_push, rx_pop, tx_push, tx_pop;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [RX_AW:0]   rx_level;
    logic [TX_AW:0]   tx_level;
    logic [7:0]       rx_rdata, tx_rdata, rx_lvl8, tx_lvl8, rx_thr;
    logic             h_ovf_q, h_unf_q, d_ovf_q, d_unf_q, tmo_q, irq_q, irq_d;
    logic [19:0]      ctrl_q;
    logic [W_TMO-1:0] reload_q, cnt_q, cnt_d;
    logic             tmo_hit;

    assign h_sel   = h_acc && (h_ch == 3'(c));
    assign d_sel   = d_acc && (d_ch == 3'(c));
    assign rx_push = h_sel && host_pwrite && (h_reg == 2'd1);
    assign tx_pop  = h_sel && !host_pwrite && (h_reg == 2'd1);
    assign tx_push = d_sel && dev_pwrite && (d_reg == 2'd1);
    assign rx_pop  = d_sel && !dev_pwrite && (d_reg == 2'd1);

    vuart_fifo #(.DEPTH(RX_DEPTH)) u_rx (
      .clk(clk), .rst_n(rst_n), .push_i(rx_push), .wdata_i(host_pwdata[7:0]), .pop_i(rx_pop),
      .rdata_o(rx_rdata), .level_o(rx_level), .full_o(rx_full), .empty_o(rx_empty)
    );
    vuart_fifo #(.DEPTH(TX_DEPTH)) u_tx (
      .clk(clk), .rst_n(rst_n), .push_i(tx_push), .wdata_i(dev_pwdata[7:0]), .pop_i(tx_pop),
      .rdata_o(tx_rdata), .level_o(tx_level), .full_o(tx_full), .empty_o(tx_empty)
    );

    assign rx_lvl8 = 8'(rx_level);
    assign tx_lvl8 = 8'(tx_level);
    assign rx_thr  = ctrl_q[11:4];

    // Idle timer only runs while device RX holds data that nobody is moving.
    always_comb begin
      cnt_d   = cnt_q;
      tmo_hit = 1'b0;
      if ((rx_push && !rx_full) || (rx_pop && !rx_empty) || rx_empty) begin
        cnt_d = reload_q;
      end else if ((reload_q != '0) && (cnt_q != '0)) begin
        cnt_d   = cnt_q - W_TMO'(1);
        tmo_hit = (cnt_q == W_TMO'(1));
      end
    end

    assign irq_d = (ctrl_q[0] && (rx_lvl8 >= ((rx_thr == 8'd0) ? 8'd1 : rx_thr)))
                || (ctrl_q[1] && (tx_lvl8 <= ctrl_q[19:12]))
                || (ctrl_q[2] && tmo_q)
                || (ctrl_q[3] && (d_ovf_q || d_unf_q));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        h_ovf_q  <= 1'b0;
        h_unf_q  <= 1'b0;
        d_ovf_q  <= 1'b0;
        d_unf_q  <= 1'b0;
        tmo_q    <= 1'b0;
        irq_q    <= 1'b0;
        ctrl_q   <= '0;
        reload_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (h_sel && host_pwrite && (h_reg == 2'd0)) begin
          if (host_pwdata[24]) h_ovf_q <= 1'b0;
          if (host_pwdata[25]) h_unf_q <= 1'b0;
        end
        if (d_sel && dev_pwrite && (d_reg == 2'd0)) begin
          if (dev_pwdata[24]) d_ovf_q <= 1'b0;
          if (dev_pwdata[25]) d_unf_q <= 1'b0;
          if (dev_pwdata[26]) tmo_q   <= 1'b0;
        end
        // New events override a same-cycle clear so none is lost.
        if (rx_push && rx_full)   h_ovf_q <= 1'b1;
        if (tx_pop && tx_empty)   h_unf_q <= 1'b1;
        if (tx_push && tx_full)   d_ovf_q <= 1'b1;
        if (rx_pop && rx_empty)   d_unf_q <= 1'b1;
        if (tmo_hit)              tmo_q   <= 1'b1;
        if (d_sel && dev_pwrite && (d_reg == 2'd2)) ctrl_q   <= dev_pwdata[19:0];
        if (d_sel && dev_pwrite && (d_reg == 2'd3)) reload_q <= dev_pwdata[W_TMO-1:0];
        cnt_q <= cnt_d;
        irq_q <= irq_d;
      end
    end

    assign irq[c]    = irq_q;
    assign d_stat[c] = {5'b0, tmo_q, d_unf_q, d_ovf_q, tx_lvl8, rx_lvl8, 6'b0, !tx_full, !rx_empty};
    assign h_stat[c] = {5'b0, 1'b0, h_unf_q, h_ovf_q, rx_lvl8, tx_lvl8, 6'b0, !rx_full, !tx_empty};
    assign d_fifo[c] = rx_empty ? 32'b0 : {23'b0, 1'b1, rx_rdata};
    assign h_fifo[c] = tx_empty ? 32'b0 : {23'b0, 1'b1, tx_rdata};
    assign d_ctrl[c] = {12'b0, ctrl_q};
    assign d_tmo[c]  = 32'(reload_q);
  end

  // Host sees IRQCTRL/TMO as read-zero and rejects writes to them.
  always_comb begin
    host_prdata  = '0;
    host_pslverr = 1'b0;
    if (h_acc) begin
      host_pslverr = 1'b1;
      for (int c = 0; c < N_CHAN; c++) begin
        if (h_ch == 3'(c)) begin
          host_pslverr = host_pwrite && h_reg[1];
          if (!host_pwrite) begin
            case (h_reg)
              2'd0:    host_prdata = h_stat[c];
              2'd1:    host_prdata = h_fifo[c];
              default: host_prdata = '0;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    dev_prdata  = '0;
    dev_pslverr = 1'b0;
    if (d_acc) begin
      dev_pslverr = 1'b1;
      for (int c = 0; c < N_CHAN; c++) begin
        if (d_ch == 3'(c)) begin
          dev_pslverr = 1'b0;
          if (!dev_pwrite) begin
            case (d_reg)
              2'd0:    dev_prdata = d_stat[c];
              2'd1:    dev_prdata = d_fifo[c];
              2'd2:    dev_prdata = d_ctrl[c];
              default: dev_prdata = d_tmo[c];
            endcase
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vuart_mc.sv
// Directed bench for vuart_mc with default parameters (2 channels, RX 8, TX 16, 8-bit timeout).
module tb_vuart_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  irq;
  logic        host_psel, host_penable, host_pwrite, host_pready, host_pslverr;
  logic [9:0]  host_paddr;
  logic [31:0] host_pwdata, host_prdata;
  logic        dev_psel, dev_penable, dev_pwrite, dev_pready, dev_pslverr;
  logic [15:0] dev_paddr;
  logic [31:0] dev_pwdata, dev_prdata;

  logic [31:0] h_rd, d_rd;
  logic        h_err, d_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  vuart_mc dut (
    .clk(clk), .rst_n(rst_n), .irq(irq),
    .host_psel(host_psel), .host_penable(host_penable), .host_pwrite(host_pwrite),
    .host_paddr(host_paddr), .host_pwdata(host_pwdata), .host_prdata(host_prdata),
    .host_pready(host_pready), .host_pslverr(host_pslverr),
    .dev_psel(dev_psel), .dev_penable(dev_penable), .dev_pwrite(dev_pwrite),
    .dev_paddr(dev_paddr), .dev_pwdata(dev_pwdata), .dev_prdata(dev_prdata),
    .dev_pready(dev_pready), .dev_pslverr(dev_pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hacc(input logic wr, input logic [9:0] a, input logic [31:0] wd);
    @(negedge clk);
    host_psel = 1'b1; host_penable = 1'b0; host_pwrite = wr; host_paddr = a; host_pwdata = wd;
    @(negedge clk);
    host_penable = 1'b1;
    #1;
    h_rd = host_prdata; h_err = host_pslverr;
    @(negedge clk);
    host_psel = 1'b0; host_penable = 1'b0; host_pwrite = 1'b0;
  endtask

  task automatic dacc(input logic wr, input logic [15:0] a, input logic [31:0] wd);
    @(negedge clk);
    dev_psel = 1'b1; dev_penable = 1'b0; dev_pwrite = wr; dev_paddr = a; dev_pwdata = wd;
    @(negedge clk);
    dev_penable = 1'b1;
    #1;
    d_rd = dev_prdata; d_err = dev_pslverr;
    @(negedge clk);
    dev_psel = 1'b0; dev_penable = 1'b0; dev_pwrite = 1'b0;
  endtask

  // Host FIFO write and device FIFO read land in the same access cycle.
  task automatic both_acc(input logic [9:0] ha, input logic [31:0] hwd, input logic [15:0] da);
    @(negedge clk);
    host_psel = 1'b1; host_penable = 1'b0; host_pwrite = 1'b1; host_paddr = ha; host_pwdata = hwd;
    dev_psel  = 1'b1; dev_penable  = 1'b0; dev_pwrite  = 1'b0; dev_paddr  = da; dev_pwdata  = '0;
    @(negedge clk);
    host_penable = 1'b1; dev_penable = 1'b1;
    #1;
    h_err = host_pslverr; d_rd = dev_prdata; d_err = dev_pslverr;
    @(negedge clk);
    host_psel = 1'b0; host_penable = 1'b0; host_pwrite = 1'b0;
    dev_psel  = 1'b0; dev_penable  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    host_psel = 0; host_penable = 0; host_pwrite = 0; host_paddr = '0; host_pwdata = '0;
    dev_psel  = 0; dev_penable  = 0; dev_pwrite  = 0; dev_paddr  = '0; dev_pwdata  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_host_prdata_idle", host_prdata, 32'h0);
    chk("rst_dev_prdata_idle", dev_prdata, 32'h0);
    dacc(1'b0, 16'h000, 0); chk("rst_dev_stat0", d_rd, 32'h0000_0002);
    hacc(1'b0, 10'h000, 0); chk("rst_host_stat0", h_rd, 32'h0000_0002);
    chk("rst_host_pslverr", 32'(h_err), 32'h0);

    // Host -> dev on channel 1, then read past empty
    hacc(1'b1, 10'h014, 32'h41);
    hacc(1'b1, 10'h014, 32'h42);
    dacc(1'b0, 16'h010, 0); chk("ch1_dev_stat_lvl2", d_rd, 32'h0000_0203);
    dacc(1'b0, 16'h014, 0); chk("ch1_pop0", d_rd, 32'h0000_0141);
    dacc(1'b0, 16'h014, 0); chk("ch1_pop1", d_rd, 32'h0000_0142);
    dacc(1'b0, 16'h014, 0); chk("ch1_pop_empty", d_rd, 32'h0000_0000);
    dacc(1'b0, 16'h010, 0); chk("ch1_unf_set", d_rd, 32'h0200_0002);
    dacc(1'b1, 16'h010, 32'h0200_0000);
    dacc(1'b0, 16'h010, 0); chk("ch1_unf_clr", d_rd, 32'h0000_0002);

    // Dev -> host overflow on channel 0
    for (int i = 0; i < 17; i++) dacc(1'b1, 16'h004, 32'(i));
    dacc(1'b0, 16'h000, 0); chk("ch0_tx_full_dev_stat", d_rd, 32'h0110_0000);
    hacc(1'b0, 10'h000, 0); chk("ch0_tx_full_host_stat", h_rd, 32'h0000_1003);
    for (int i = 0; i < 16; i++) begin
      hacc(1'b0, 10'h004, 0);
      chk("ch0_host_pop_order", h_rd, 32'h100 | 32'(i));
    end
    dacc(1'b1, 16'h000, 32'h0100_0000);
    dacc(1'b0, 16'h000, 0); chk("ch0_ovf_clr", d_rd, 32'h0000_0002);

    // RX level interrupt, threshold 3
    dacc(1'b1, 16'h008, 32'h31);
    dacc(1'b0, 16'h008, 0); chk("ch0_irqctrl_rb", d_rd, 32'h0000_0031);
    hacc(1'b1, 10'h004, 32'h10);
    hacc(1'b1, 10'h004, 32'h11);
    chk("irq_lvl2_low", 32'(irq), 32'h0);
    hacc(1'b1, 10'h004, 32'h12);
    chk("irq_push3_same_cycle_low", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_push3_next_cycle_high", 32'(irq), 32'h1);
    dacc(1'b0, 16'h004, 0); chk("irq_pop_data", d_rd, 32'h0000_0110);
    chk("irq_pop_same_cycle_high", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_pop_next_cycle_low", 32'(irq), 32'h0);
    dacc(1'b0, 16'h004, 0); chk("drain_111", d_rd, 32'h0000_0111);
    dacc(1'b0, 16'h004, 0); chk("drain_112", d_rd, 32'h0000_0112);

    // Idle timeout: a pop reloads the counter, then it expires
    dacc(1'b1, 16'h00C, 32'd5);
    dacc(1'b1, 16'h008, 32'h4);
    hacc(1'b1, 10'h004, 32'hA0);
    hacc(1'b1, 10'h004, 32'hA1);
    dacc(1'b0, 16'h004, 0); chk("tmo_pop_data", d_rd, 32'h0000_01A0);
    repeat (4) @(negedge clk);
    chk("tmo_irq_low_4", 32'(irq), 32'h0);
    @(negedge clk);
    chk("tmo_irq_low_5", 32'(irq), 32'h0);
    @(negedge clk);
    chk("tmo_irq_high_6", 32'(irq), 32'h1);
    dacc(1'b0, 16'h000, 0); chk("tmo_dev_stat", d_rd, 32'h0400_0103);
    dacc(1'b1, 16'h000, 32'h0400_0000);
    dacc(1'b0, 16'h004, 0); chk("tmo_drain", d_rd, 32'h0000_01A1);
    dacc(1'b0, 16'h000, 0); chk("tmo_clr_stat", d_rd, 32'h0000_0002);
    chk("tmo_clr_irq", 32'(irq), 32'h0);
    dacc(1'b1, 16'h008, 32'h0);

    // Error responses
    hacc(1'b0, 10'h020, 0);
    chk("err_host_ch2_slverr", 32'(h_err), 32'h1);
    chk("err_host_ch2_rdata", h_rd, 32'h0);
    dacc(1'b1, 16'h024, 32'h55); chk("err_dev_ch2_wr_slverr", 32'(d_err), 32'h1);
    dacc(1'b0, 16'h020, 0);
    chk("err_dev_ch2_rd_slverr", 32'(d_err), 32'h1);
    chk("err_dev_ch2_rd_rdata", d_rd, 32'h0);
    hacc(1'b1, 10'h008, 32'hFF); chk("err_host_irqctrl_wr", 32'(h_err), 32'h1);
    dacc(1'b0, 16'h008, 0); chk("err_irqctrl_unchanged", d_rd, 32'h0);
    hacc(1'b0, 10'h008, 0);
    chk("host_irqctrl_rd_zero", h_rd, 32'h0);
    chk("host_irqctrl_rd_ok", 32'(h_err), 32'h0);

    // Full RX with simultaneous push and pop
    for (int i = 0; i < 8; i++) hacc(1'b1, 10'h014, 32'hB0 + 32'(i));
    hacc(1'b0, 10'h010, 0); chk("full_host_stat", h_rd, 32'h0008_0000);
    dacc(1'b0, 16'h010, 0); chk("full_dev_stat", d_rd, 32'h0000_0803);
    both_acc(10'h014, 32'hEE, 16'h014);
    chk("both_pop_data", d_rd, 32'h0000_01B0);
    hacc(1'b0, 10'h010, 0); chk("both_host_ovf", h_rd, 32'h0107_0002);
    dacc(1'b0, 16'h010, 0); chk("both_dev_lvl7", d_rd, 32'h0000_0703);
    for (int i = 1; i < 8; i++) begin
      dacc(1'b0, 16'h014, 0);
      chk("both_drain_order", d_rd, 32'h1B0 + 32'(i));
    end
    dacc(1'b0, 16'h010, 0); chk("both_drained_stat", d_rd, 32'h0000_0002);

    // Reset in mid-operation
    hacc(1'b1, 10'h004, 32'h77);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dacc(1'b0, 16'h000, 0); chk("mid_rst_dev_stat0", d_rd, 32'h0000_0002);
    hacc(1'b0, 10'h010, 0); chk("mid_rst_host_stat1", h_rd, 32'h0000_0002);
    chk("mid_rst_irq", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
